// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Shared constants, helpers and types for the VGA raster timing
//             generator. Holds the 640x480@60 default geometry, a helper that
//             sums the four timing terms into a total line/frame length, and
//             the packed bundle of decoded single-bit timing flags.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  // 640x480@60 reference geometry (pixels / lines)
  localparam int unsigned c_H_DISPLAY     = 640;
  localparam int unsigned c_H_FRONT_PORCH = 16;
  localparam int unsigned c_H_SYNC        = 96;
  localparam int unsigned c_H_BACK_PORCH  = 48;
  localparam int unsigned c_V_DISPLAY     = 480;
  localparam int unsigned c_V_FRONT_PORCH = 10;
  localparam int unsigned c_V_SYNC        = 2;
  localparam int unsigned c_V_BACK_PORCH  = 33;

  // Total period of one axis (HMAX or VMAX) from its four terms.
  function automatic int unsigned timing_total(input int unsigned display,
                                               input int unsigned front_porch,
                                               input int unsigned sync,
                                               input int unsigned back_porch);
    return display + front_porch + sync + back_porch;
  endfunction

  // Decoded single-bit timing flags; coordinates travel alongside them.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } timing_flags_t;

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : vga_delay_line
//  Purpose  : DEPTH-stage register chain with an individual enable per stage
//             and a per-bit reset value. Used to delay the decoded timing
//             bundle so that every output arrives on the same tick.
//  Ports    : clk_i   - clock
//             rst_i   - synchronous active-high reset (loads RESET_VAL)
//             en_i    - one enable bit per stage; a stage holds when low
//             data_i  - input word
//             data_o  - word after DEPTH enabled advances
//  Revision : 1.0  initial release
// ============================================================================
module vga_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DEPTH-1:0] en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic [WIDTH-1:0] w_stage_in;

    if (s == 0) begin : g_head
      assign w_stage_in = data_i;
    end else begin : g_body
      assign w_stage_in = stage_q[s-1];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q[s] <= RESET_VAL;
      end else if (en_i[s]) begin
        stage_q[s] <= w_stage_in;
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Owns the horizontal
//             and vertical pixel counters, decodes sync / video-enable /
//             line and frame strobes from them and registers the whole set
//             through a PIPE_STAGES deep aligned output pipeline.
//  Ports    : i_Clk         - system clock
//             i_Reset       - synchronous active-high reset
//             i_Pix_En      - pixel tick; counters and pipeline advance on 1
//             o_hsync       - horizontal sync, active at HSYNC_POL
//             o_vsync       - vertical sync, active at VSYNC_POL
//             o_video_on    - inside the visible area
//             o_x, o_y      - raster coordinates
//             o_line_start  - tick where o_x == 0
//             o_frame_start - tick where o_x == 0 and o_y == 0
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY     = c_H_DISPLAY,
  parameter int unsigned H_FRONT_PORCH = c_H_FRONT_PORCH,
  parameter int unsigned H_SYNC        = c_H_SYNC,
  parameter int unsigned H_BACK_PORCH  = c_H_BACK_PORCH,
  parameter int unsigned V_DISPLAY     = c_V_DISPLAY,
  parameter int unsigned V_FRONT_PORCH = c_V_FRONT_PORCH,
  parameter int unsigned V_SYNC        = c_V_SYNC,
  parameter int unsigned V_BACK_PORCH  = c_V_BACK_PORCH,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter int unsigned PIPE_STAGES   = 1,
  localparam int unsigned HMAX = timing_total(H_DISPLAY, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH),
  localparam int unsigned VMAX = timing_total(V_DISPLAY, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH),
  localparam int unsigned HW   = $clog2(HMAX),
  localparam int unsigned VW   = $clog2(VMAX)
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic          i_Pix_En,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic [HW-1:0] o_x,
  output logic [VW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_STAGES must be in 1..4");
  end
  if (H_FRONT_PORCH == 0 || H_SYNC == 0 || H_BACK_PORCH == 0 ||
      V_FRONT_PORCH == 0 || V_SYNC == 0 || V_BACK_PORCH == 0) begin : g_bad_geom
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  // Full-width compare constants; all are below HMAX / VMAX so they fit.
  localparam logic [HW-1:0] c_H_LAST     = HW'(HMAX - 1);
  localparam logic [VW-1:0] c_V_LAST     = VW'(VMAX - 1);
  localparam logic [HW-1:0] c_H_DISP     = HW'(H_DISPLAY);
  localparam logic [VW-1:0] c_V_DISP     = VW'(V_DISPLAY);
  localparam logic [HW-1:0] c_HS_START   = HW'(H_DISPLAY + H_FRONT_PORCH);
  localparam logic [HW-1:0] c_HS_END     = HW'(H_DISPLAY + H_FRONT_PORCH + H_SYNC);
  localparam logic [VW-1:0] c_VS_START   = VW'(V_DISPLAY + V_FRONT_PORCH);
  localparam logic [VW-1:0] c_VS_END     = VW'(V_DISPLAY + V_FRONT_PORCH + V_SYNC);

  localparam int unsigned c_PW = $bits(timing_flags_t) + HW + VW;

  localparam timing_flags_t c_IDLE_FLAGS = '{
    hsync:       ~HSYNC_POL,
    vsync:       ~VSYNC_POL,
    video_on:    1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };
  localparam logic [c_PW-1:0] c_IDLE = {c_IDLE_FLAGS, {HW{1'b0}}, {VW{1'b0}}};

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_Pix_En) begin
      if (h_q == c_H_LAST) begin
        h_d = '0;
        // v only moves on the h wrap, so the corner wrap lands on (0,0)
        v_d = (v_q == c_V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the current counter position
  // ---------------------------------------------------------------------------
  timing_flags_t w_flags;

  always_comb begin
    w_flags             = c_IDLE_FLAGS;
    w_flags.hsync       = (h_q >= c_HS_START && h_q < c_HS_END) ? HSYNC_POL : ~HSYNC_POL;
    w_flags.vsync       = (v_q >= c_VS_START && v_q < c_VS_END) ? VSYNC_POL : ~VSYNC_POL;
    w_flags.video_on    = (h_q < c_H_DISP) && (v_q < c_V_DISP);
    w_flags.line_start  = (h_q == '0);
    w_flags.frame_start = (h_q == '0) && (v_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Aligned output pipeline; flags and coordinates share one word so they
  // cannot drift apart.
  // ---------------------------------------------------------------------------
  logic [c_PW-1:0] w_pipe_in;
  logic [c_PW-1:0] w_pipe_out;
  timing_flags_t   w_out_flags;

  assign w_pipe_in = {w_flags, h_q, v_q};

  vga_delay_line #(
    .WIDTH     (c_PW),
    .DEPTH     (PIPE_STAGES),
    .RESET_VAL (c_IDLE)
  ) u_pipe (
    .clk_i  (i_Clk),
    .rst_i  (i_Reset),
    .en_i   ({PIPE_STAGES{i_Pix_En}}),
    .data_i (w_pipe_in),
    .data_o (w_pipe_out)
  );

  assign {w_out_flags, o_x, o_y} = w_pipe_out;

  assign o_hsync       = w_out_flags.hsync;
  assign o_vsync       = w_out_flags.vsync;
  assign o_video_on    = w_out_flags.video_on;
  assign o_line_start  = w_out_flags.line_start;
  assign o_frame_start = w_out_flags.frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Three instances share
//             clock, reset and pixel enable:
//               A - tiny raster H 4/1/1/1, V 3/1/1/1, active-low, 1 stage
//               B - small raster H 5/2/3/1, V 4/1/2/2, active-high, 3 stages
//               C - 640x480 defaults
//             Expected outputs come from the count of enabled ticks since the
//             last reset: position index k = ticks - stages, x = k mod HMAX,
//             y = (k div HMAX) mod VMAX, with the sync/video windows applied.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic i_Reset;
  logic i_Pix_En;

  always #5 clk = ~clk;

  // Instance A
  logic       a_hs, a_vs, a_von, a_ls, a_fs;
  logic [2:0] a_x;
  logic [2:0] a_y;
  // Instance B
  logic       b_hs, b_vs, b_von, b_ls, b_fs;
  logic [3:0] b_x;
  logic [3:0] b_y;
  // Instance C
  logic       c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x;
  logic [9:0] c_y;

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT_PORCH(1), .H_SYNC(1), .H_BACK_PORCH(1),
    .V_DISPLAY(3), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_STAGES(1)
  ) u_dut_a (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_video_on(a_von),
    .o_x(a_x), .o_y(a_y), .o_line_start(a_ls), .o_frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_DISPLAY(5), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(1),
    .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_STAGES(3)
  ) u_dut_b (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_video_on(b_von),
    .o_x(b_x), .o_y(b_y), .o_line_start(b_ls), .o_frame_start(b_fs)
  );

  vga_timing_gen u_dut_c (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .o_hsync(c_hs), .o_vsync(c_vs), .o_video_on(c_von),
    .o_x(c_x), .o_y(c_y), .o_line_start(c_ls), .o_frame_start(c_fs)
  );

  typedef struct packed {
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit ls;
    bit fs;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ticks = 0;   // enabled ticks since the last reset

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", tag, obs, exp, n_ticks, $time);
    end
  endtask

  // Reference: what an ideal raster shows after cnt enabled ticks.
  function automatic exp_t model(input int hd, input int hf, input int hs, input int hb,
                                 input int vd, input int vf, input int vs, input int vb,
                                 input bit hp, input bit vp, input int p, input int cnt);
    exp_t e;
    int   hmax;
    int   vmax;
    int   k;
    hmax = hd + hf + hs + hb;
    vmax = vd + vf + vs + vb;
    e.x = 0; e.y = 0; e.hs = ~hp; e.vs = ~vp; e.von = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    if (cnt >= p) begin
      k     = cnt - p;
      e.x   = k % hmax;
      e.y   = (k / hmax) % vmax;
      e.hs  = (e.x >= hd + hf && e.x < hd + hf + hs) ? hp : ~hp;
      e.vs  = (e.y >= vd + vf && e.y < vd + vf + vs) ? vp : ~vp;
      e.von = (e.x < hd) && (e.y < vd);
      e.ls  = (e.x == 0);
      e.fs  = (e.x == 0) && (e.y == 0);
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t e;
    e = model(4, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0, 1, n_ticks);
    chk("A.hsync", int'(a_hs), int'(e.hs));
    chk("A.vsync", int'(a_vs), int'(e.vs));
    chk("A.video_on", int'(a_von), int'(e.von));
    chk("A.x", int'(a_x), e.x);
    chk("A.y", int'(a_y), e.y);
    chk("A.line_start", int'(a_ls), int'(e.ls));
    chk("A.frame_start", int'(a_fs), int'(e.fs));

    e = model(5, 2, 3, 1, 4, 1, 2, 2, 1'b1, 1'b1, 3, n_ticks);
    chk("B.hsync", int'(b_hs), int'(e.hs));
    chk("B.vsync", int'(b_vs), int'(e.vs));
    chk("B.video_on", int'(b_von), int'(e.von));
    chk("B.x", int'(b_x), e.x);
    chk("B.y", int'(b_y), e.y);
    chk("B.line_start", int'(b_ls), int'(e.ls));
    chk("B.frame_start", int'(b_fs), int'(e.fs));

    e = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, n_ticks);
    chk("C.hsync", int'(c_hs), int'(e.hs));
    chk("C.vsync", int'(c_vs), int'(e.vs));
    chk("C.video_on", int'(c_von), int'(e.von));
    chk("C.x", int'(c_x), e.x);
    chk("C.y", int'(c_y), e.y);
    chk("C.line_start", int'(c_ls), int'(e.ls));
    chk("C.frame_start", int'(c_fs), int'(e.fs));
  endtask

  // Apply one clock of stimulus, then compare 1 time unit after the edge.
  task automatic step(input bit r, input bit en);
    i_Reset  = r;
    i_Pix_En = en;
    @(posedge clk);
    #1;
    if (r) n_ticks = 0;
    else if (en) n_ticks++;
    check_all();
  endtask

  initial begin
    i_Reset  = 1'b1;
    i_Pix_En = 1'b1;

    // Reset with enable high: reset must win
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Continuous enable: several full frames of A and B
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1);

    // Enable toggling 1/0: outputs frozen on low cycles
    for (int i = 0; i < 200; i++) step(1'b0, (i % 2) == 0);

    // Single-clock reset mid-frame, then restart
    step(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1);

    // Random enable with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0);
    end

    // Long enabled run: default raster crosses its hsync window and line wrap
    step(1'b1, 1'b0);
    for (int i = 0; i < 900; i++) step(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
